// File: rtl/pent_dram_arb.sv
// Pentagon DRAM sequencer: shares the array between video fetch, Z80 CPU and
// Z80 refresh in two 4-clock windows per 8-clock character slot.
module pent_dram_arb #(
  parameter int ADDR_W = 18,
  parameter int COL_W  = 9
) (
  input  logic              clk14m,
  input  logic              rst_n,
  input  logic              sync,
  input  logic              vid_act,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              ref_req,
  input  logic [COL_W-1:0]  ref_row,
  output logic [COL_W-1:0]  ram_a,
  output logic              ram_ras_n,
  output logic              ram_cas_n,
  output logic              ram_we_n,
  output logic              vid_stb,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [2:0]        phase,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_REF  = 2'd3
  } owner_e;

  logic [2:0]        phase_q, phase_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [COL_W-1:0]  a_q, a_d;
  logic              ras_q, ras_d, cas_q, cas_d, we_q, we_d;
  logic              vid_stb_q, vid_stb_d, cpu_ack_q, cpu_ack_d;
  logic              cpu_done_q, cpu_done_d, ref_done_q, ref_done_d;
  logic              cpu_pend, ref_pend, data_owner;

  assign cpu_pend   = cpu_req & ~cpu_done_q;
  assign ref_pend   = ref_req & ~ref_done_q;
  assign data_owner = (owner_q == OWN_VID) || (owner_q == OWN_CPU);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    phase_d    = sync ? 3'd0 : phase_q + 3'd1;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    a_d        = '0;
    ras_d      = 1'b1;
    cas_d      = 1'b1;
    we_d       = 1'b1;
    vid_stb_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    cpu_done_d = cpu_req ? cpu_done_q : 1'b0;
    ref_done_d = ref_req ? ref_done_q : 1'b0;

    // A sync mid-window always lands on step 0, so an aborted access simply
    // never reaches step 3 and its done flag is never set.
    case (phase_d[1:0])
      2'd0: begin
        if (!phase_d[2] && vid_act) begin
          owner_d = OWN_VID;
          addr_d  = vid_addr;
          wr_d    = 1'b0;
        end else if (ref_pend) begin
          owner_d = OWN_REF;
          addr_d  = {ref_row, {COL_W{1'b0}}};
          wr_d    = 1'b0;
        end else if (cpu_pend) begin
          owner_d = OWN_CPU;
          addr_d  = cpu_addr;
          wr_d    = cpu_we;
        end else begin
          owner_d = OWN_NONE;
          addr_d  = '0;
          wr_d    = 1'b0;
        end
        a_d = addr_d[ADDR_W-1:COL_W];
      end
      2'd1: begin
        a_d   = addr_q[ADDR_W-1:COL_W];
        ras_d = (owner_q == OWN_NONE);
      end
      default: begin
        a_d   = addr_q[COL_W-1:0];
        ras_d = (owner_q == OWN_NONE);
        cas_d = ~data_owner;
        we_d  = ~((owner_q == OWN_CPU) && wr_q);
        if (phase_d[1:0] == 2'd3) begin
          vid_stb_d = (owner_q == OWN_VID);
          cpu_ack_d = (owner_q == OWN_CPU);
          if (owner_q == OWN_CPU) cpu_done_d = 1'b1;
          if (owner_q == OWN_REF) ref_done_d = 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk14m) begin
    if (!rst_n) begin
      phase_q    <= 3'd0;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      a_q        <= '0;
      ras_q      <= 1'b1;
      cas_q      <= 1'b1;
      we_q       <= 1'b1;
      vid_stb_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      ref_done_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      a_q        <= a_d;
      ras_q      <= ras_d;
      cas_q      <= cas_d;
      we_q       <= we_d;
      vid_stb_q  <= vid_stb_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_done_q <= cpu_done_d;
      ref_done_q <= ref_done_d;
    end
  end

  assign phase     = phase_q;
  assign owner     = owner_q;
  assign ram_a     = a_q;
  assign ram_ras_n = ras_q;
  assign ram_cas_n = cas_q;
  assign ram_we_n  = we_q;
  assign vid_stb   = vid_stb_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_wait  = cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_pent_dram_arb.sv
// Directed bench for pent_dram_arb: idle, video, CPU read/write, refresh,
// sync abort and mid-access reset, with hand-computed expectations.
module tb_pent_dram_arb;

  logic        clk14m = 1'b0;
  logic        rst_n;
  logic        sync;
  logic        vid_act;
  logic [17:0] vid_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic        ref_req;
  logic [8:0]  ref_row;
  logic [8:0]  ram_a;
  logic        ram_ras_n, ram_cas_n, ram_we_n;
  logic        vid_stb, cpu_ack, cpu_wait;
  logic [2:0]  phase;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_ph = 3'd0;

  pent_dram_arb dut (
    .clk14m(clk14m), .rst_n(rst_n), .sync(sync), .vid_act(vid_act),
    .vid_addr(vid_addr), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .ref_req(ref_req), .ref_row(ref_row),
    .ram_a(ram_a), .ram_ras_n(ram_ras_n), .ram_cas_n(ram_cas_n),
    .ram_we_n(ram_we_n), .vid_stb(vid_stb), .cpu_ack(cpu_ack),
    .cpu_wait(cpu_wait), .phase(phase), .owner(owner)
  );

  always #5 clk14m = ~clk14m;

  initial begin
    #200us;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock; the phase model follows reset and sync exactly as the slot counter should.
  task automatic tick();
    @(posedge clk14m);
    if (!rst_n)    exp_ph = 3'd0;
    else if (sync) exp_ph = 3'd0;
    else           exp_ph = exp_ph + 3'd1;
    @(negedge clk14m);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; vid_act = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; ref_req = 1'b0; ref_row = '0;
    @(negedge clk14m);
    ticks(2);
    check("rst_phase", phase, 0);
    check("rst_owner", owner, 0);
    check("rst_strobes", {ram_ras_n, ram_cas_n, ram_we_n}, 3'b111);
    check("rst_ram_a", ram_a, 0);
    check("rst_stb_ack", {vid_stb, cpu_ack}, 2'b00);
    rst_n = 1'b1;

    // Idle with sync at phase 7 every slot.
    for (int i = 0; i < 16; i++) begin
      sync = (exp_ph == 3'd7);
      tick();
      check("idle_phase", phase, exp_ph);
      check("idle_strobes", {ram_ras_n, ram_cas_n, ram_we_n}, 3'b111);
      check("idle_owner", owner, 0);
    end
    sync = 1'b0;

    // Video fetch: row 0x021, col 0x121.
    ticks(7);
    vid_act = 1'b1; vid_addr = 18'h0_4321;
    tick();
    check("vid_p0_owner", owner, 1);
    check("vid_p0_ras", ram_ras_n, 1);
    check("vid_p0_a", ram_a, 9'h021);
    tick();
    check("vid_p1_phase", phase, 1);
    check("vid_p1_ras_cas", {ram_ras_n, ram_cas_n}, 2'b01);
    check("vid_p1_a", ram_a, 9'h021);
    vid_addr = 18'h0_0000;
    tick();
    check("vid_p2_ras_cas", {ram_ras_n, ram_cas_n}, 2'b00);
    check("vid_p2_a_latched", ram_a, 9'h121);
    check("vid_p2_stb", vid_stb, 0);
    check("vid_p2_we", ram_we_n, 1);
    tick();
    check("vid_p3_cas", ram_cas_n, 0);
    check("vid_p3_a", ram_a, 9'h121);
    check("vid_p3_stb", vid_stb, 1);
    tick();
    check("vid_p4_ras", ram_ras_n, 1);
    check("vid_p4_stb", vid_stb, 0);
    check("vid_p4_owner", owner, 0);

    // CPU read raised at phase 1 while video owns window A: row 0x152, col 0x1C3.
    ticks(5);
    check("cpu_rd_p1_phase", phase, 1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h2_A5C3;
    #1 check("cpu_rd_wait_p1", cpu_wait, 1);
    tick(); check("cpu_rd_wait_p2", cpu_wait, 1);
    tick(); check("cpu_rd_owner_p3", owner, 1);
    tick();
    check("cpu_rd_owner_p4", owner, 2);
    check("cpu_rd_row", ram_a, 9'h152);
    check("cpu_rd_wait_p4", cpu_wait, 1);
    tick(); check("cpu_rd_ras_p5", ram_ras_n, 0);
    tick();
    check("cpu_rd_cas_p6", ram_cas_n, 0);
    check("cpu_rd_we_p6", ram_we_n, 1);
    check("cpu_rd_col", ram_a, 9'h1C3);
    check("cpu_rd_ack_p6", cpu_ack, 0);
    tick();
    check("cpu_rd_phase7", phase, 7);
    check("cpu_rd_ack_p7", cpu_ack, 1);
    check("cpu_rd_wait_p7", cpu_wait, 0);
    check("cpu_rd_we_p7", ram_we_n, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("cpu_rd_no_reack", cpu_ack, 0);
      if (exp_ph == 3'd4) check("cpu_rd_no_reserve", owner, 0);
    end
    cpu_req = 1'b0; vid_act = 1'b0;
    tick();
    check("idle_a_owner", owner, 0);

    // Refresh and CPU write both pending at phase 3: row 0x1AB; cpu row 0x081 col 0x003.
    ticks(3);
    check("rw_p3_phase", phase, 3);
    ref_req = 1'b1; ref_row = 9'h1AB;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h1_0203;
    tick();
    check("ref_owner", owner, 3);
    check("ref_row_a", ram_a, 9'h1AB);
    tick();
    check("ref_ras_p5", ram_ras_n, 0);
    check("ref_row_p5", ram_a, 9'h1AB);
    tick();
    check("ref_p6_strobes", {ram_ras_n, ram_cas_n, ram_we_n}, 3'b011);
    tick();
    check("ref_p7_strobes", {ram_ras_n, ram_cas_n, ram_we_n}, 3'b011);
    check("ref_p7_ack", cpu_ack, 0);
    tick();
    check("wr_owner", owner, 2);
    check("wr_row", ram_a, 9'h081);
    tick();
    check("wr_ras_p1", ram_ras_n, 0);
    tick();
    check("wr_p2_strobes", {ram_ras_n, ram_cas_n, ram_we_n}, 3'b000);
    check("wr_col", ram_a, 9'h003);
    tick();
    check("wr_p3_we", ram_we_n, 0);
    check("wr_p3_ack", cpu_ack, 1);
    ref_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("wr_after_owner", owner, 0);

    // Sync at phase 5 aborts a CPU read in window B: row 0x185, col 0x007.
    ticks(7);
    check("sy_p3_phase", phase, 3);
    cpu_req = 1'b1; cpu_addr = 18'h3_0A07; vid_act = 1'b1;
    tick();
    check("sy_owner_p4", owner, 2);
    tick();
    check("sy_ras_p5", ram_ras_n, 0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sy_phase0", phase, 0);
    check("sy_strobes_high", {ram_ras_n, ram_cas_n, ram_we_n}, 3'b111);
    check("sy_no_ack", cpu_ack, 0);
    check("sy_still_wait", cpu_wait, 1);
    check("sy_vid_owner", owner, 1);
    ticks(4);
    check("sy_rerun_owner", owner, 2);
    check("sy_rerun_row", ram_a, 9'h185);
    ticks(2);
    check("sy_rerun_col", ram_a, 9'h007);
    check("sy_p6_ack", cpu_ack, 0);
    tick();
    check("sy_rerun_ack", cpu_ack, 1);
    cpu_req = 1'b0;

    // Reset during phase 2 of a video access.
    ticks(3);
    check("rv_p2_phase", phase, 2);
    check("rv_p2_cas", ram_cas_n, 0);
    rst_n = 1'b0;
    tick();
    check("rv_strobes_high", {ram_ras_n, ram_cas_n, ram_we_n}, 3'b111);
    check("rv_no_stb", vid_stb, 0);
    check("rv_phase", phase, 0);
    rst_n = 1'b1;
    tick();
    check("rv_rel_phase1", phase, exp_ph);
    check("rv_rel_stb", vid_stb, 0);
    check("rv_rel_ras", ram_ras_n, 1);
    tick();
    check("rv_rel_phase2", phase, 2);
    check("rv_rel_stb2", vid_stb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
